s3_chien_forney: RTL and testbench
==================================

// Module: s3_chien_forney
// PURPOSE
//  Stage 3 of the t=2 RS(N,N-4) GF(2^8) decoder, directly downstream of the KES stage. On kes_done, captures
//  lambda(x)=l0+l1*x+l2*x^2 and omega(x)=w0+w1*x, runs a Chien search over all N positions and computes Forney
//  magnitudes. Streams one error value per cycle, highest-degree symbol first, to the correction XOR stage.
// PARAMETERS
//  N    255  codeword length in symbols, 5..255; position i = coefficient of x^i, stream order i=N-1..0
//  FCR  1    first consecutive root b of the generator (0 or 1); selects X^(1-b) Forney factor
// PORTS
//  clk         in   1  system clock
//  rstn        in   1  async active-low reset
//  kes_done    in   1  1-cycle strobe; lambda/omega inputs valid in the same cycle
//  rs_lambda0  in   8  lambda x^0 coefficient (any nonzero common scale with omega is allowed)
//  rs_lambda1  in   8  lambda x^1 coefficient
//  rs_lambda2  in   8  lambda x^2 coefficient
//  rs_omega0   in   8  omega x^0 coefficient
//  rs_omega1   in   8  omega x^1 coefficient
//  out_vld     out  1  error value valid, N consecutive cycles per codeword
//  out_err     out  8  error magnitude for the current position; 8'h00 when no root
//  out_last    out  1  with out_vld, marks position 0
//  err_cnt     out  2  roots found; valid with out_last
//  dec_fail    out  1  valid with out_last; uncorrectable codeword
//  ovf         out  1  sticky; a pending job was overwritten; cleared only by reset
// BEHAVIOUR
//  - GF(2^8) primitive poly 0x11D, alpha=8'h02. Lambda'(x)=l1 (char 2); inv_l1 is computed once per job.
//  - Reset: all outputs 0, FSM IDLE, pending buffer empty, ovf=0. Reset mid-job drops the job with no further out_vld.
//  - FSM IDLE->RUN on job load; RUN stays N cycles, then next job (pending) or IDLE.
//  - Load (edge after kes_done at T): term regs Lj <= lj*alpha^(j*(256-N)), Wj likewise,
//    Xr <= alpha^(N-1), inv_l1 <= inverse(l1), deg <= 2 if l2!=0, else 1 if l1!=0, else 0.
//  - Each RUN cycle: Lj <= Lj*alpha^j and Wj <= Wj*alpha^j (constant multipliers); Xr <= Xr*alpha^-1.
//  - Eval: root = (L0^L1^L2)==0; mag = (W0^W1)*inv_l1, times Xr if FCR=0; registered as
//    out_err = root ? mag : 0. Root count saturates at 3 internally.
//  - Latency: first out_vld at T+2, out_last at T+N+1. No stalls; downstream always accepts.
//  - dec_fail = (roots != deg) | (deg==2 & l1==0) | (deg==0 & (w0|w1)!=0); err_cnt = roots[1:0].
//  - kes_done while RUN: inputs go to a 1-deep pending buffer and the next job starts on the cycle after the
//    current last symbol, giving back-to-back out_vld with no bubble. kes_done with pending full: overwrite
//    and set ovf. kes_done in the same cycle as the final RUN cycle: load directly, no pending.
//  - All-zero lambda (l0=l1=l2=0): every position is a root; the count saturates and dec_fail=1.
// STRUCTURE
//  - Shared package rs_pkg: GF_POLY, ALPHA, and a gf_pow(a,e) constant function that feeds the load/step
//    constant localparams. It also holds the FSM state enum.
//  - Reuse gf2m8_multi for variable products.
//  - One new sub-module gf2m8_inv: combinational inverse by Fermat a^254, inv(0)=0.
//  - Constant multipliers are inlined XOR networks.
// TESTING  (N=255, FCR=1)
//  - No error: lambda={01,00,00}, omega={00,00} -> 255 x out_err=00, out_last at T+256, err_cnt=0, dec_fail=0
//  - Single error at pos 0: lambda={01,01,00}, omega={5A,00} -> only last symbol out_err=5A, err_cnt=1
//  - Scaled copy: lambda={02,02,00}, omega={B4,00} -> identical stream to previous test
//  - Double error at pos 0,1: lambda={01,03,02}, omega={03,00} -> last two symbols 01,01, err_cnt=2, fail=0
//  - Repeated root: lambda={01,00,01}, omega={01,00} -> dec_fail=1 at out_last
//  - kes_done at T, T+100, T+101 -> ovf=1, second job lost, third starts at T+257, contiguous out_vld.
//    Then assert rstn=0 mid-job -> outputs 0 immediately and ovf cleared.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the RS t=2 decoder stages.
//   GF_POLY / ALPHA : field polynomial 0x11D and primitive element 0x02
//   gf_mul          : generic field product (used for constants and small sub-blocks)
//   gf_pow          : a^e, feeds elaboration-time constant localparams
//   mul_alpha       : x*alpha as a fixed XOR network
//   div_alpha       : x*alpha^-1 as a fixed XOR network
//   cf_state_e      : Chien/Forney stage FSM states
//   coef_t          : one job's lambda/omega coefficient set
package rs_pkg;

   localparam logic [8:0] GF_POLY = 9'h11D;
   localparam logic [7:0] GF_RED  = GF_POLY[7:0];
   localparam logic [7:0] ALPHA   = 8'h02;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } cf_state_e;

   typedef struct packed {
      logic [7:0] l0;
      logic [7:0] l1;
      logic [7:0] l2;
      logic [7:0] w0;
      logic [7:0] w1;
   } coef_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [7:0] gf_pow(input logic [7:0] a, input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 0; k < 255; k++) begin
         if (k < e) r = gf_mul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] mul_alpha(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
   endfunction

   // alpha^-1 = 0x8E: an odd value has the reduction polynomial folded back in before the shift.
   function automatic logic [7:0] div_alpha(input logic [7:0] x);
      return {1'b0, x[7:1]} ^ (x[0] ? 8'h8E : 8'h00);
   endfunction

endpackage

// File: rtl/gf2m8_inv.sv
// Combinational GF(2^8) inverse by Fermat: a^-1 = a^254, so inv(0) = 0.
//   a_i   : operand
//   inv_o : a_i^254
module gf2m8_inv
   import rs_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] inv_o
);
   logic [7:0] sq [1:7];
   logic [7:0] acc;

   // 254 = 2+4+...+128: multiply the seven successive squares together.
   always_comb begin
      sq[1] = gf_mul(a_i, a_i);
      for (int k = 2; k <= 7; k++) sq[k] = gf_mul(sq[k-1], sq[k-1]);
      acc = sq[1];
      for (int k = 2; k <= 7; k++) acc = gf_mul(acc, sq[k]);
      inv_o = acc;
   end
endmodule

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier (poly 0x11D).
//   a_i, b_i : operands
//   p_o      : product a_i*b_i
module gf2m8_multi
   import rs_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] p_o
);
   assign p_o = gf_mul(a_i, b_i);
endmodule

// File: rtl/s3_chien_forney.sv
// Stage 3 of the t=2 RS(N,N-4) decoder: Chien search plus Forney magnitudes.
//   clk, rstn            : clock, async active-low reset
//   kes_done             : 1-cycle strobe, rs_lambda*/rs_omega* valid with it
//   rs_lambda0..2        : error locator coefficients
//   rs_omega0..1         : error evaluator coefficients
//   out_vld/out_err      : one magnitude per cycle, position N-1 first, 0 when no root
//   out_last             : marks position 0; err_cnt and dec_fail are valid with it
//   ovf                  : sticky, a pending job was overwritten
// Handshake: no backpressure; out_vld is high for N consecutive cycles per job.
module s3_chien_forney
   import rs_pkg::*;
#(
   parameter int N   = 255,
   parameter int FCR = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       kes_done,
   input  logic [7:0] rs_lambda0,
   input  logic [7:0] rs_lambda1,
   input  logic [7:0] rs_lambda2,
   input  logic [7:0] rs_omega0,
   input  logic [7:0] rs_omega1,
   output logic       out_vld,
   output logic [7:0] out_err,
   output logic       out_last,
   output logic [1:0] err_cnt,
   output logic       dec_fail,
   output logic       ovf
);
   // Position N-1 is evaluated at alpha^-(N-1) = alpha^(256-N).
   localparam int         SHIFT    = (256 - N) % 255;
   localparam logic [7:0] LOAD_C1  = gf_pow(ALPHA, SHIFT);
   localparam logic [7:0] LOAD_C2  = gf_pow(ALPHA, (2 * SHIFT) % 255);
   localparam logic [7:0] X_INIT   = gf_pow(ALPHA, N - 1);
   localparam logic [7:0] LAST_POS = 8'(N - 1);

   cf_state_e  state_q, state_d;
   coef_t      pend_q, in_c, src;
   logic       pend_vld_q, ovf_q;
   logic       load, load_pend, pend_wr, pend_clr, ovf_set;
   logic [7:0] pos_q;
   logic [1:0] cnt_q, deg_q, src_deg, roots_tot;
   logic       l1_zero_q, w_nz_q;
   logic [7:0] lam0_q, lam1_q, lam2_q, om0_q, om1_q, xr_q, inv_l1_q;
   logic [7:0] ld_l1, ld_l2, ld_w1, src_inv, mag_base, mag_x, mag;
   logic       run, last_pos, root, fail;
   logic       out_vld_q, out_last_q, dec_fail_q;
   logic [7:0] out_err_q;
   logic [1:0] err_cnt_q;

   assign in_c     = '{l0: rs_lambda0, l1: rs_lambda1, l2: rs_lambda2, w0: rs_omega0, w1: rs_omega1};
   assign src      = load_pend ? pend_q : in_c;
   assign run      = (state_q == ST_RUN);
   assign last_pos = (pos_q == LAST_POS);
   assign src_deg  = (src.l2 != 8'h00) ? 2'd2 : ((src.l1 != 8'h00) ? 2'd1 : 2'd0);

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      load_pend = 1'b0;
      pend_wr   = 1'b0;
      pend_clr  = 1'b0;
      ovf_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (kes_done) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_pos) begin
               // Final symbol: chain straight into the next job so out_vld stays contiguous.
               if (pend_vld_q) begin
                  load      = 1'b1;
                  load_pend = 1'b1;
                  pend_wr   = kes_done;
                  pend_clr  = ~kes_done;
               end else if (kes_done) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (kes_done) begin
               pend_wr = 1'b1;
               ovf_set = pend_vld_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (pend_wr) begin
            pend_q     <= in_c;
            pend_vld_q <= 1'b1;
         end else if (pend_clr) begin
            pend_vld_q <= 1'b0;
         end
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   gf2m8_multi u_ld_l1 (.a_i(src.l1), .b_i(LOAD_C1), .p_o(ld_l1));
   gf2m8_multi u_ld_l2 (.a_i(src.l2), .b_i(LOAD_C2), .p_o(ld_l2));
   gf2m8_multi u_ld_w1 (.a_i(src.w1), .b_i(LOAD_C1), .p_o(ld_w1));
   gf2m8_inv   u_inv   (.a_i(src.l1), .inv_o(src_inv));

   // Lambda'(x) = l1 in characteristic 2, so one inverse per job suffices.
   gf2m8_multi u_mag   (.a_i(om0_q ^ om1_q), .b_i(inv_l1_q), .p_o(mag_base));
   gf2m8_multi u_magx  (.a_i(mag_base), .b_i(xr_q), .p_o(mag_x));

   assign mag       = (FCR == 0) ? mag_x : mag_base;
   assign root      = ((lam0_q ^ lam1_q ^ lam2_q) == 8'h00);
   assign roots_tot = (root && cnt_q != 2'd3) ? cnt_q + 2'd1 : cnt_q;
   assign fail      = (roots_tot != deg_q) | ((deg_q == 2'd2) & l1_zero_q) | ((deg_q == 2'd0) & w_nz_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos_q     <= '0;
         cnt_q     <= '0;
         deg_q     <= '0;
         l1_zero_q <= 1'b0;
         w_nz_q    <= 1'b0;
         lam0_q    <= '0;
         lam1_q    <= '0;
         lam2_q    <= '0;
         om0_q     <= '0;
         om1_q     <= '0;
         xr_q      <= '0;
         inv_l1_q  <= '0;
      end else if (load) begin
         pos_q     <= '0;
         cnt_q     <= '0;
         deg_q     <= src_deg;
         l1_zero_q <= (src.l1 == 8'h00);
         w_nz_q    <= ((src.w0 | src.w1) != 8'h00);
         lam0_q    <= src.l0;
         lam1_q    <= ld_l1;
         lam2_q    <= ld_l2;
         om0_q     <= src.w0;
         om1_q     <= ld_w1;
         xr_q      <= X_INIT;
         inv_l1_q  <= src_inv;
      end else if (run) begin
         pos_q  <= pos_q + 8'd1;
         cnt_q  <= roots_tot;
         lam1_q <= mul_alpha(lam1_q);
         lam2_q <= mul_alpha(mul_alpha(lam2_q));
         om1_q  <= mul_alpha(om1_q);
         xr_q   <= div_alpha(xr_q);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_vld_q  <= 1'b0;
         out_err_q  <= '0;
         out_last_q <= 1'b0;
         err_cnt_q  <= '0;
         dec_fail_q <= 1'b0;
      end else begin
         out_vld_q  <= run;
         out_err_q  <= (run && root) ? mag : 8'h00;
         out_last_q <= run && last_pos;
         err_cnt_q  <= (run && last_pos) ? roots_tot : 2'd0;
         dec_fail_q <= run && last_pos && fail;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_err  = out_err_q;
   assign out_last = out_last_q;
   assign err_cnt  = err_cnt_q;
   assign dec_fail = dec_fail_q;
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_s3_chien_forney.sv
// Bench for s3_chien_forney (N=255, FCR=1): log/antilog reference model, expected queue, monitor.
module tb_s3_chien_forney;
   localparam int N   = 255;
   localparam int FCR = 1;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       kes_done = 1'b0;
   logic [7:0] rs_lambda0 = '0, rs_lambda1 = '0, rs_lambda2 = '0, rs_omega0 = '0, rs_omega1 = '0;
   logic       out_vld, out_last, dec_fail, ovf;
   logic [7:0] out_err;
   logic [1:0] err_cnt;

   s3_chien_forney #(.N(N), .FCR(FCR)) dut (
      .clk(clk), .rstn(rstn), .kes_done(kes_done),
      .rs_lambda0(rs_lambda0), .rs_lambda1(rs_lambda1), .rs_lambda2(rs_lambda2),
      .rs_omega0(rs_omega0), .rs_omega1(rs_omega1),
      .out_vld(out_vld), .out_err(out_err), .out_last(out_last),
      .err_cnt(err_cnt), .dec_fail(dec_fail), .ovf(ovf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [7:0] exp_tab [0:254];
   int         log_tab [0:255];
   int         checks = 0;
   int         errors = 0;
   // entry: {cycle[31:0], last, fail, cnt[1:0], err[7:0]}
   logic [43:0] exp_q [$];

   task automatic build_tables();
      logic [7:0] x;
      x = 8'h01;
      for (int k = 0; k < 255; k++) begin
         exp_tab[k] = x;
         log_tab[x] = k;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      end
      log_tab[0] = 0;
   endtask

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_tab[(log_tab[a] + log_tab[b]) % 255];
   endfunction

   function automatic logic [7:0] m_div(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_tab[(log_tab[a] - log_tab[b] + 255) % 255];
   endfunction

   // Expected stream for a job whose load edge closes cycle t (first out_vld at t+2).
   task automatic push_job(input int t, input logic [7:0] l0, l1, l2, w0, w1);
      logic [7:0] errs [N];
      logic [7:0] xinv, lam, om, mag;
      int roots, deg;
      logic fail;
      roots = 0;
      for (int i = N - 1; i >= 0; i--) begin
         xinv = exp_tab[(255 - i) % 255];
         lam  = l0 ^ m_mul(l1, xinv) ^ m_mul(l2, m_mul(xinv, xinv));
         mag  = 8'h00;
         if (lam == 8'h00) begin
            om  = w0 ^ m_mul(w1, xinv);
            mag = m_div(om, l1);
            if (FCR == 0) mag = m_mul(mag, exp_tab[i]);
            if (roots < 3) roots++;
         end
         errs[N-1-i] = mag;
      end
      deg  = (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
      fail = (roots != deg) || (deg == 2 && l1 == 0) || (deg == 0 && (w0 | w1) != 0);
      for (int k = 0; k < N; k++) begin
         if (k == N - 1) exp_q.push_back({32'(t + 2 + k), 1'b1, fail, 2'(roots), errs[k]});
         else            exp_q.push_back({32'(t + 2 + k), 1'b0, 1'b0, 2'd0, errs[k]});
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (out_vld) begin
         logic [43:0] e;
         logic bad;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out cyc=%0d got err=%02h last=%0b", cyc, out_err, out_last);
         end else begin
            e = exp_q.pop_front();
            bad = (cyc != int'(e[43:12])) || (out_err != e[7:0]) || (out_last != e[11]);
            if (e[11]) bad = bad || (err_cnt != e[9:8]) || (dec_fail != e[10]);
            if (bad) begin
               errors++;
               $display("FAIL symbol cyc=%0d got err=%02h last=%0b cnt=%0d fail=%0b, expected cyc=%0d err=%02h last=%0b cnt=%0d fail=%0b",
                        cyc, out_err, out_last, err_cnt, dec_fail,
                        int'(e[43:12]), e[7:0], e[11], e[9:8], e[10]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic issue(input logic [7:0] l0, l1, l2, w0, w1, output int t);
      rs_lambda0 = l0; rs_lambda1 = l1; rs_lambda2 = l2;
      rs_omega0  = w0; rs_omega1  = w1;
      kes_done   = 1'b1;
      t          = cyc;
      @(posedge clk); #1;
      kes_done   = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout remaining=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_job(input string name, input logic [7:0] l0, l1, l2, w0, w1);
      int t;
      push_job(cyc, l0, l1, l2, w0, w1);
      issue(l0, l1, l2, w0, w1, t);
      drain(name, N + 20);
   endtask

   task automatic check_idle_outputs(input string name, input logic exp_ovf);
      checks++;
      if (out_vld !== 1'b0 || out_err !== 8'h00 || out_last !== 1'b0 ||
          err_cnt !== 2'd0 || dec_fail !== 1'b0 || ovf !== exp_ovf) begin
         errors++;
         $display("FAIL %s got vld=%0b err=%02h last=%0b cnt=%0d fail=%0b ovf=%0b, required zeros with ovf=%0b",
                  name, out_vld, out_err, out_last, err_cnt, dec_fail, ovf, exp_ovf);
      end
   endtask

   // Lambda built from chosen error positions so roots actually occur, with a random common scale.
   task automatic rand_coefs(output logic [7:0] l0, l1, l2, w0, w1);
      int nr, p, q;
      logic [7:0] s, x1, x2;
      nr = $urandom_range(0, 3);
      s  = 8'($urandom_range(1, 255));
      p  = $urandom_range(0, N - 1);
      q  = (p + $urandom_range(1, N - 1)) % N;
      x1 = exp_tab[p];
      x2 = exp_tab[q];
      w0 = 8'($urandom_range(0, 255));
      w1 = 8'($urandom_range(0, 255));
      case (nr)
         0:       begin l0 = s; l1 = 8'h00;                 l2 = 8'h00; end
         1:       begin l0 = s; l1 = m_mul(s, x1);          l2 = 8'h00; end
         2:       begin l0 = s; l1 = m_mul(s, x1 ^ x2);     l2 = m_mul(s, m_mul(x1, x2)); end
         default: begin
            l0 = 8'($urandom_range(0, 255)); l1 = 8'($urandom_range(0, 255)); l2 = 8'($urandom_range(0, 255));
         end
      endcase
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, t1;
      logic [7:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
      build_tables();

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset_state", 1'b0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("idle_after_reset", 1'b0);

      run_job("no_error",    8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      run_job("single_pos0", 8'h01, 8'h01, 8'h00, 8'h5A, 8'h00);
      run_job("scaled_copy", 8'h02, 8'h02, 8'h00, 8'hB4, 8'h00);
      run_job("double_pos01",8'h01, 8'h03, 8'h02, 8'h03, 8'h00);
      run_job("repeat_root", 8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
      run_job("zero_lambda", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_job("deg0_omega",  8'h05, 8'h00, 8'h00, 8'h07, 8'h00);

      // kes_done during the final RUN cycle loads directly.
      rand_coefs(a0, a1, a2, a3, a4);
      rand_coefs(b0, b1, b2, b3, b4);
      push_job(cyc, a0, a1, a2, a3, a4);
      issue(a0, a1, a2, a3, a4, t0);
      wait_until(t0 + N);
      push_job(cyc, b0, b1, b2, b3, b4);
      issue(b0, b1, b2, b3, b4, t1);
      drain("direct_chain", 2 * N + 20);

      // kes_done mid-job goes to the pending buffer.
      rand_coefs(a0, a1, a2, a3, a4);
      rand_coefs(b0, b1, b2, b3, b4);
      push_job(cyc, a0, a1, a2, a3, a4);
      issue(a0, a1, a2, a3, a4, t0);
      wait_until(t0 + 50);
      push_job(t0 + N, b0, b1, b2, b3, b4);
      issue(b0, b1, b2, b3, b4, t1);
      drain("pending_chain", 2 * N + 20);
      check_idle_outputs("no_ovf_yet", 1'b0);

      for (int j = 0; j < 16; j++) begin
         rand_coefs(a0, a1, a2, a3, a4);
         run_job("random_job", a0, a1, a2, a3, a4);
      end

      // Overwrite of pending: the second job is lost, the third follows the first with no gap.
      rand_coefs(a0, a1, a2, a3, a4);
      rand_coefs(b0, b1, b2, b3, b4);
      push_job(cyc, a0, a1, a2, a3, a4);
      issue(a0, a1, a2, a3, a4, t0);
      wait_until(t0 + 100);
      issue(8'h01, 8'h01, 8'h00, 8'h77, 8'h00, t1);
      push_job(t0 + N, b0, b1, b2, b3, b4);
      issue(b0, b1, b2, b3, b4, t1);
      drain("overwrite", 2 * N + 20);
      check_idle_outputs("ovf_sticky", 1'b1);

      // Reset in the middle of a job: outputs drop at once, ovf clears, nothing more appears.
      rand_coefs(a0, a1, a2, a3, a4);
      push_job(cyc, a0, a1, a2, a3, a4);
      issue(a0, a1, a2, a3, a4, t0);
      wait_until(t0 + 50);
      rstn = 1'b0;
      #1;
      check_idle_outputs("mid_job_reset", 1'b0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (N + 20) @(posedge clk);
      #1;
      check_idle_outputs("quiet_after_reset", 1'b0);

      run_job("after_reset", 8'h01, 8'h03, 8'h02, 8'h03, 8'h00);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty remaining=%0d required=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
